cdb_arbiter: RTL

- Round-robin arbiter for the common data bus (CDB) of the out-of-order core.
- Shares the single CDB broadcast slot among NUM_REQ functional-unit result ports, using a valid/ready handshake on each port.
- The winner's tag and data are steered through the select datapath and broadcast from a registered output stage to the reservation stations and the ROB.

---
 rtl/cdb_pkg.sv | 24 ++
 rtl/cdb_arbiter_rr_pick.sv | 47 ++++
 rtl/cdb_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/cdb_pkg.sv
// Shared constants and the broadcast register format for the CDB arbiter.
package cdb_pkg;

    localparam int CDB_NUM_REQ = 4;
    localparam int CDB_DATA_W  = 32;
    localparam int CDB_TAG_W   = 6;
    localparam int CDB_SRC_W   = $clog2(CDB_NUM_REQ);

    // Broadcast register contents. Field widths follow the default build;
    // the arbiter casts into and out of these fields.
    typedef struct packed {
        logic                  valid;
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
        logic [CDB_SRC_W-1:0]  src;
    } cdb_entry_t;

    // Wrap a sum of two in-range indices back into 0..n-1. The requester
    // count need not be a power of two, so the wrap is an explicit compare.
    function automatic int rr_wrap(input int a, input int n);
        return (a >= n) ? (a - n) : a;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Round-robin pick: rotate requests so ptr sits at bit 0, take the lowest
// set bit, then rotate the one-hot grant back to port order.
module rr_pick
    import cdb_pkg::*;
#(
    parameter int N     = CDB_NUM_REQ,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [N-1:0]     rot;
    logic [N-1:0]     rot_gnt;
    logic [IDX_W-1:0] first;
    logic [IDX_W-1:0] k;
    logic             found;

    // Rotate, fixed-priority select, un-rotate.
    always_comb begin
        rot     = '0;
        rot_gnt = '0;
        gnt_o   = '0;
        first   = '0;
        found   = 1'b0;
        k       = '0;
        for (int j = 0; j < N; j++) begin
            k      = IDX_W'(rr_wrap(j + int'(ptr_i), N));
            rot[j] = req_i[k];
        end
        for (int j = 0; j < N; j++) begin
            if (rot[j] && !found) begin
                rot_gnt[j] = 1'b1;
                first      = IDX_W'(j);
                found      = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            k        = IDX_W'(rr_wrap(j + int'(ptr_i), N));
            gnt_o[k] = rot_gnt[j];
        end
        idx_o = IDX_W'(rr_wrap(int'(first) + int'(ptr_i), N));
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among functional-unit result
// ports, AND-OR steering of the winner, and a registered broadcast stage.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = CDB_NUM_REQ,
    parameter int DATA_W  = CDB_DATA_W,
    parameter int TAG_W   = CDB_TAG_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        cdb_stall,
    input  logic                        flush,
    output logic                        cdb_valid,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic [DATA_W-1:0]           cdb_data,
    output logic [$clog2(NUM_REQ)-1:0]  cdb_src
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_REQ - 1);

    logic [SRC_W-1:0]  ptr_q, ptr_d;
    cdb_entry_t        entry_q, entry_d;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [SRC_W-1:0]  pick_idx;
    logic [TAG_W-1:0]  tag_sel;
    logic [DATA_W-1:0] data_sel;
    logic              fire;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (SRC_W)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // Grant is suppressed while in reset, stalled, or flushing.
    always_comb begin
        req_ready = (rst_n && !cdb_stall && !flush) ? pick_gnt : '0;
        fire      = |req_ready;
    end

    // One-hot AND-OR select of the winner's tag and data.
    always_comb begin
        tag_sel  = '0;
        data_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            tag_sel  = tag_sel  | ({TAG_W{req_ready[i]}}  & req_tag[i*TAG_W +: TAG_W]);
            data_sel = data_sel | ({DATA_W{req_ready[i]}} & req_data[i*DATA_W +: DATA_W]);
        end
    end

    // Next broadcast and pointer: flush beats stall, stall holds everything.
    always_comb begin
        entry_d = entry_q;
        ptr_d   = ptr_q;
        if (flush) begin
            entry_d.valid = 1'b0;
        end else if (!cdb_stall) begin
            if (fire) begin
                entry_d.valid = 1'b1;
                entry_d.tag   = CDB_TAG_W'(tag_sel);
                entry_d.data  = CDB_DATA_W'(data_sel);
                entry_d.src   = CDB_SRC_W'(pick_idx);
                ptr_d         = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
            end else begin
                entry_d.valid = 1'b0;
            end
        end
    end

    // Broadcast register and priority pointer; reset drops any broadcast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
            ptr_q   <= '0;
        end else begin
            entry_q <= entry_d;
            ptr_q   <= ptr_d;
        end
    end

    assign cdb_valid = entry_q.valid;
    assign cdb_tag   = TAG_W'(entry_q.tag);
    assign cdb_data  = DATA_W'(entry_q.data);
    assign cdb_src   = SRC_W'(entry_q.src);

endmodule
